// File: rtl/ad9361_burst_framer.sv
// Groups gated AD9361 I/Q samples into bursts and frames each one as HDR0, HDR1, payload, TRAILER
// into a first-word-fall-through output FIFO. The input is never stalled; overflow truncates or drops.
module ad9361_burst_framer #(
  parameter int FIFO_DEPTH = 512,
  parameter int GAP_LEN    = 8,
  parameter int MAX_BURST  = 4096,
  parameter int CHANNEL    = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_in,
  input  logic [11:0] data_i_in,
  input  logic [11:0] data_q_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_last,
  output logic        drop_pulse
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int IW = $clog2(GAP_LEN + 1);
  localparam logic [AW:0]   DEPTH_W     = (AW+1)'(FIFO_DEPTH);
  localparam logic [AW:0]   FREE_START  = (AW+1)'(4);
  localparam logic [AW:0]   FREE_RESTART = (AW+1)'(5);
  localparam logic [AW:0]   FREE_PAYLOAD = (AW+1)'(2);
  localparam logic [IW-1:0] GAP_W       = IW'(GAP_LEN);
  localparam logic [15:0]   MAX_W       = 16'(MAX_BURST);
  localparam logic [7:0]    CH          = 8'(CHANNEL);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    HDR0    = 3'd1,
    HDR1    = 3'd2,
    BURST   = 3'd3,
    DRAIN   = 3'd4,
    TRAILER = 3'd5
  } state_t;

  state_t        state;
  logic [31:0]   timestamp;
  logic [31:0]   ts;
  logic [15:0]   seq;
  logic [15:0]   len;
  logic          ovf;
  logic          maxf;
  logic          discard;
  logic [IW-1:0] idle_cnt;
  logic [IW-1:0] idle_nxt;
  logic          gap_done;
  logic          burst_full;
  logic          room;
  logic          start_ok;

  logic [2:0]    dly_v;
  logic [11:0]   dly_i [3];
  logic [11:0]   dly_q [3];
  logic [31:0]   payload;

  logic [32:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [AW:0]   free;
  logic          wr_en;
  logic          rd_en;
  logic [32:0]   wr_word;

  assign payload = {{4{dly_i[2][11]}}, dly_i[2], {4{dly_q[2][11]}}, dly_q[2]};

  always_comb begin
    free       = DEPTH_W - count;
    idle_nxt   = valid_in ? '0 : idle_cnt + 1'b1;
    gap_done   = (idle_nxt == GAP_W);
    burst_full = (len == MAX_W);
    room       = (free >= FREE_PAYLOAD);
    // In TRAILER the trailer word itself still lands this cycle, so one extra slot is needed.
    start_ok   = (state == TRAILER) ? (free >= FREE_RESTART) : (free >= FREE_START);
    wr_en      = 1'b0;
    wr_word    = '0;
    case (state)
      HDR0: begin
        wr_en   = 1'b1;
        wr_word = {1'b0, 8'hA5, CH, seq};
      end
      HDR1: begin
        wr_en   = 1'b1;
        wr_word = {1'b0, ts};
      end
      BURST: begin
        if (dly_v[2] && room && !burst_full) begin
          wr_en   = 1'b1;
          wr_word = {1'b0, payload};
        end
      end
      TRAILER: begin
        wr_en   = 1'b1;
        wr_word = {1'b1, 8'h5C, 6'b0, maxf, ovf, len};
      end
      default: ;
    endcase
  end

  // Three-stage input delay so payload lands after the two header words.
  always_ff @(posedge clk) begin
    if (rst) begin
      dly_v <= '0;
      for (int k = 0; k < 3; k++) begin
        dly_i[k] <= '0;
        dly_q[k] <= '0;
      end
    end else begin
      dly_v    <= {dly_v[1:0], valid_in};
      dly_i[0] <= data_i_in;
      dly_q[0] <= data_q_in;
      dly_i[1] <= dly_i[0];
      dly_q[1] <= dly_q[0];
      dly_i[2] <= dly_i[1];
      dly_q[2] <= dly_q[1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      timestamp  <= '0;
      ts         <= '0;
      seq        <= '0;
      len        <= '0;
      ovf        <= 1'b0;
      maxf       <= 1'b0;
      discard    <= 1'b0;
      idle_cnt   <= '0;
      drop_pulse <= 1'b0;
    end else begin
      timestamp  <= timestamp + 32'd1;
      drop_pulse <= 1'b0;
      case (state)
        HDR0: state <= HDR1;
        HDR1: state <= BURST;
        BURST: begin
          if (dly_v[2]) begin
            if (!room) begin
              ovf   <= 1'b1;
              state <= DRAIN;
            end else if (burst_full) begin
              maxf  <= 1'b1;
              state <= DRAIN;
            end else begin
              len <= len + 16'd1;
            end
          end
          idle_cnt <= idle_nxt;
          if (gap_done) state <= TRAILER;
        end
        DRAIN: begin
          idle_cnt <= idle_nxt;
          if (gap_done) begin
            state   <= discard ? IDLE : TRAILER;
            discard <= 1'b0;
          end
        end
        IDLE, TRAILER: begin
          if (state == TRAILER) begin
            seq  <= seq + 16'd1;
            len  <= '0;
            ovf  <= 1'b0;
            maxf <= 1'b0;
          end
          idle_cnt <= '0;
          state    <= IDLE;
          if (valid_in) begin
            ts <= timestamp;
            if (start_ok) begin
              state <= HDR0;
            end else begin
              drop_pulse <= 1'b1;
              discard    <= 1'b1;
              state      <= DRAIN;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= wr_word;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (rd_en) rd_ptr <= rd_ptr + 1'b1;
      count <= count + {{AW{1'b0}}, wr_en} - {{AW{1'b0}}, rd_en};
    end
  end

  // Output handshake: a word transfers on a clock edge where out_valid && out_ready; while
  // out_valid is high and out_ready low, out_data/out_last stay unchanged and out_valid stays high.
  assign rd_en     = out_valid & out_ready;
  assign out_valid = (count != '0);
  assign out_data  = mem[rd_ptr][31:0];
  assign out_last  = out_valid & mem[rd_ptr][32];

endmodule
